// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared defaults, width derivation and reset values for the FIFO control slice
package fifo_ctrl_pkg;
   localparam int DEF_MEM_SIZE  = 8;
   localparam int DEF_WORD_SIZE = 12;
   localparam int DEF_PTR       = 3;
   localparam int PTR_RST       = 0;
   localparam int CNT_RST       = 0;
   // occupancy counter must hold 0..MEM_SIZE, one bit wider than a pointer
   function automatic int cnt_w(input int ptr);
      return ptr + 1;
   endfunction
endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: producer/consumer requests, thresholds and FIFO status; err_clr exists only with FIFO_ERR_STICKY_EN
interface fifo_ctrl_if import fifo_ctrl_pkg::*; #(
   parameter int PTR = DEF_PTR,
   parameter int CNT = cnt_w(PTR)
);
   logic           fifo_wr;
   logic           fifo_rd;
   logic [CNT-1:0] umbral_af;
   logic [CNT-1:0] umbral_ae;
`ifdef FIFO_ERR_STICKY_EN
   logic           err_clr;
`endif
   logic [PTR-1:0] wr_ptr;
   logic [PTR-1:0] rd_ptr;
   logic           push;
   logic           pop;
   logic [CNT-1:0] fifo_count;
   logic           fifo_full;
   logic           fifo_empty;
   logic           almost_full;
   logic           almost_empty;
   logic           overflow;
   logic           underflow;
   modport master (
      output fifo_wr, fifo_rd, umbral_af, umbral_ae,
`ifdef FIFO_ERR_STICKY_EN
      output err_clr,
`endif
      input  wr_ptr, rd_ptr, push, pop, fifo_count, fifo_full, fifo_empty,
      input  almost_full, almost_empty, overflow, underflow
   );
   modport slave (
      input  fifo_wr, fifo_rd, umbral_af, umbral_ae,
`ifdef FIFO_ERR_STICKY_EN
      input  err_clr,
`endif
      output wr_ptr, rd_ptr, push, pop, fifo_count, fifo_full, fifo_empty,
      output almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/fifo_ptr.sv
// fifo_ptr: pointer register that advances on inc and wraps from MEM_SIZE-1 to 0 (any depth)
module fifo_ptr import fifo_ctrl_pkg::*; #(
   parameter int MEM_SIZE = DEF_MEM_SIZE,
   parameter int PTR      = DEF_PTR
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           inc,
   output logic [PTR-1:0] ptr
);
   localparam logic [PTR-1:0] LAST = PTR'(MEM_SIZE - 1);
   logic [PTR-1:0] r_ptr;
   // explicit wrap at LAST so non-power-of-two depths never reach MEM_SIZE
   always_ff @(posedge clk)
      r_ptr <= reset ? PTR'(PTR_RST) : inc ? (r_ptr == LAST ? '0 : r_ptr + 1'b1) : r_ptr;
   assign ptr = r_ptr;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO pointers, occupancy, status flags and overflow/underflow; FIFO_ERR_STICKY_EN makes errors sticky with err_clr
module fifo_ctrl import fifo_ctrl_pkg::*; #(
   parameter int MEM_SIZE  = DEF_MEM_SIZE,
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int PTR       = DEF_PTR,
   parameter int CNT       = cnt_w(PTR)
) (
   input  logic        clk,
   input  logic        reset,
   fifo_ctrl_if.slave  bus
);
   localparam logic [CNT-1:0] FULL_CNT = CNT'(MEM_SIZE);
   logic           w_push;
   logic           w_pop;
   logic           w_full;
   logic           w_empty;
   logic           w_ovf;
   logic           w_unf;
   logic [CNT-1:0] r_count;
   logic           r_ovf;
   logic           r_unf;
   generate
      if (MEM_SIZE < 2 || (1 << PTR) < MEM_SIZE || WORD_SIZE < 1) begin : g_bad_cfg
         $error("fifo_ctrl: MEM_SIZE must be >= 2 and fit in PTR bits");
      end
   endgenerate
   // strobes and flags decode from registered count; full+rd lets a write through (memory reads before write)
   always_comb begin
      w_full  = r_count == FULL_CNT;
      w_empty = r_count == '0;
      w_push  = !reset && bus.fifo_wr && (!w_full || bus.fifo_rd);
      w_pop   = !reset && bus.fifo_rd && !w_empty;
      w_ovf   = !reset && bus.fifo_wr && !w_push;
      w_unf   = !reset && bus.fifo_rd && !w_pop;
   end
   fifo_ptr #(.MEM_SIZE(MEM_SIZE), .PTR(PTR)) u_wr_ptr (
      .clk(clk), .reset(reset), .inc(w_push), .ptr(bus.wr_ptr)
   );
   fifo_ptr #(.MEM_SIZE(MEM_SIZE), .PTR(PTR)) u_rd_ptr (
      .clk(clk), .reset(reset), .inc(w_pop), .ptr(bus.rd_ptr)
   );
   // occupancy moves only when exactly one side is accepted
   always_ff @(posedge clk)
      r_count <= reset ? CNT'(CNT_RST) :
                 (w_push && !w_pop) ? r_count + 1'b1 :
                 (w_pop && !w_push) ? r_count - 1'b1 : r_count;
`ifdef FIFO_ERR_STICKY_EN
   // errors latch until err_clr; a fresh error in the clearing cycle keeps the flag set
   always_ff @(posedge clk) begin
      r_ovf <= reset ? 1'b0 : w_ovf | (r_ovf & !bus.err_clr);
      r_unf <= reset ? 1'b0 : w_unf | (r_unf & !bus.err_clr);
   end
`else
   // errors are one-cycle pulses following the refused request
   always_ff @(posedge clk) begin
      r_ovf <= reset ? 1'b0 : w_ovf;
      r_unf <= reset ? 1'b0 : w_unf;
   end
`endif
   assign bus.push         = w_push;
   assign bus.pop          = w_pop;
   assign bus.fifo_count   = r_count;
   assign bus.fifo_full    = w_full;
   assign bus.fifo_empty   = w_empty;
   assign bus.almost_full  = r_count >= bus.umbral_af;
   assign bus.almost_empty = r_count <= bus.umbral_ae;
   assign bus.overflow     = r_ovf;
   assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed scoreboard bench running depth-8 and depth-5 controllers side by side
module tb_fifo_ctrl;
   logic       clk = 0;
   logic       reset = 1;
   logic       wr = 0;
   logic       rd = 0;
   logic       clr = 0;
   logic [3:0] af = 4'd6;
   logic [3:0] ae = 4'd2;
   int         n_tests = 0;
   int         n_fail = 0;
   int         depth [2] = '{8, 5};
   int         m_cnt [2];
   int         m_wp [2];
   int         m_rp [2];
   logic       m_ovf [2];
   logic       m_unf [2];
   logic       e_push [2];
   logic       e_pop [2];
   int         q0 [$];
   int         q1 [$];
   logic [2:0] o_wp [2];
   logic [2:0] o_rp [2];
   logic [3:0] o_cnt [2];
   logic       o_push [2];
   logic       o_pop [2];
   logic       o_full [2];
   logic       o_empty [2];
   logic       o_af [2];
   logic       o_ae [2];
   logic       o_ovf [2];
   logic       o_unf [2];

   always #5 clk = ~clk;

   fifo_ctrl_if #(.PTR(3), .CNT(4)) b0 ();
   fifo_ctrl_if #(.PTR(3), .CNT(4)) b1 ();

   assign b0.fifo_wr = wr;
   assign b0.fifo_rd = rd;
   assign b0.umbral_af = af;
   assign b0.umbral_ae = ae;
   assign b1.fifo_wr = wr;
   assign b1.fifo_rd = rd;
   assign b1.umbral_af = af;
   assign b1.umbral_ae = ae;
`ifdef FIFO_ERR_STICKY_EN
   assign b0.err_clr = clr;
   assign b1.err_clr = clr;
`endif

   fifo_ctrl #(.MEM_SIZE(8), .WORD_SIZE(12), .PTR(3), .CNT(4)) u0 (.clk(clk), .reset(reset), .bus(b0));
   fifo_ctrl #(.MEM_SIZE(5), .WORD_SIZE(12), .PTR(3), .CNT(4)) u1 (.clk(clk), .reset(reset), .bus(b1));

   assign o_wp[0] = b0.wr_ptr;        assign o_wp[1] = b1.wr_ptr;
   assign o_rp[0] = b0.rd_ptr;        assign o_rp[1] = b1.rd_ptr;
   assign o_cnt[0] = b0.fifo_count;   assign o_cnt[1] = b1.fifo_count;
   assign o_push[0] = b0.push;        assign o_push[1] = b1.push;
   assign o_pop[0] = b0.pop;          assign o_pop[1] = b1.pop;
   assign o_full[0] = b0.fifo_full;   assign o_full[1] = b1.fifo_full;
   assign o_empty[0] = b0.fifo_empty; assign o_empty[1] = b1.fifo_empty;
   assign o_af[0] = b0.almost_full;   assign o_af[1] = b1.almost_full;
   assign o_ae[0] = b0.almost_empty;  assign o_ae[1] = b1.almost_empty;
   assign o_ovf[0] = b0.overflow;     assign o_ovf[1] = b1.overflow;
   assign o_unf[0] = b0.underflow;    assign o_unf[1] = b1.underflow;

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d: observed %0d expected %0d", tag, d, obs, exp);
      end
   endtask

   function automatic int nxt(input int p, input int d);
      return (p == depth[d] - 1) ? 0 : p + 1;
   endfunction

   // one clock: drive, check strobes/scoreboard before the edge, update model, check state after the edge
   task automatic cyc(input logic w, input logic r, input logic rs, input logic c);
      int a;
      logic n_o;
      logic n_u;
      wr = w; rd = r; reset = rs; clr = c;
      #1;
      for (int d = 0; d < 2; d++) begin
         e_push[d] = !rs && w && (m_cnt[d] != depth[d] || r);
         e_pop[d]  = !rs && r && m_cnt[d] != 0;
         chk("push", d, o_push[d], e_push[d]);
         chk("pop", d, o_pop[d], e_pop[d]);
         if (e_push[d]) begin
            chk("wr_ptr_at_push", d, o_wp[d], m_wp[d]);
            if (d == 0) q0.push_back(m_wp[d]); else q1.push_back(m_wp[d]);
         end
         if (e_pop[d]) begin
            a = -1;
            if (d == 0 && q0.size() > 0) a = q0.pop_front();
            if (d == 1 && q1.size() > 0) a = q1.pop_front();
            chk("rd_ptr_vs_scoreboard", d, o_rp[d], a);
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         n_o = !rs && w && !e_push[d];
         n_u = !rs && r && !e_pop[d];
         if (rs) begin
            m_cnt[d] = 0; m_wp[d] = 0; m_rp[d] = 0; m_ovf[d] = 0; m_unf[d] = 0;
            if (d == 0) q0.delete(); else q1.delete();
         end else begin
            if (e_push[d]) m_wp[d] = nxt(m_wp[d], d);
            if (e_pop[d]) m_rp[d] = nxt(m_rp[d], d);
            m_cnt[d] += int'(e_push[d]) - int'(e_pop[d]);
`ifdef FIFO_ERR_STICKY_EN
            m_ovf[d] = n_o | (m_ovf[d] & !c);
            m_unf[d] = n_u | (m_unf[d] & !c);
`else
            m_ovf[d] = n_o;
            m_unf[d] = n_u;
`endif
         end
         chk("count", d, o_cnt[d], m_cnt[d]);
         chk("wr_ptr", d, o_wp[d], m_wp[d]);
         chk("rd_ptr", d, o_rp[d], m_rp[d]);
         chk("ptr_bound", d, (o_wp[d] < depth[d]) && (o_rp[d] < depth[d]), 1);
         chk("full", d, o_full[d], m_cnt[d] == depth[d]);
         chk("empty", d, o_empty[d], m_cnt[d] == 0);
         chk("almost_full", d, o_af[d], m_cnt[d] >= int'(af));
         chk("almost_empty", d, o_ae[d], m_cnt[d] <= int'(ae));
         chk("overflow", d, o_ovf[d], m_ovf[d]);
         chk("underflow", d, o_unf[d], m_unf[d]);
      end
   endtask

   initial begin
      cyc(1, 1, 1, 0);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 1, 0, 0);
      repeat (8) cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
`ifdef FIFO_ERR_STICKY_EN
      repeat (10) cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
`endif
      af = 4'd3;
      ae = 4'd8;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("almost_full_live", d, o_af[d], m_cnt[d] >= 3);
         chk("almost_empty_live", d, o_ae[d], m_cnt[d] <= 8);
      end
      af = 4'd6;
      ae = 4'd2;
      repeat (9) cyc(0, 1, 0, 0);
      repeat (12) begin
         cyc(1, 0, 0, 0);
         cyc(0, 1, 0, 0);
      end
      cyc(1, 0, 0, 0);
      repeat (7) cyc(1, 1, 0, 0);
      repeat (3) cyc(1, 0, 0, 0);
      cyc(1, 1, 1, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      af = 4'd0;
      cyc(0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
